// File: rtl/seq_arith_core_if.sv
// Request/response bus for seq_arith_core: valid/ready request channel carrying
// opcode and operands, valid/ready response channel carrying result and flag.
interface seq_arith_core_if #(
  parameter int DWIDTH = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [1:0]        i_op;
  logic [DWIDTH-1:0] i_value_a;
  logic [DWIDTH-1:0] i_value_b;
  logic              o_valid;
  logic              i_ready;
  logic [DWIDTH-1:0] o_result;
  logic              o_div_zero;

  // Requester side
  modport master (
    output i_valid, i_op, i_value_a, i_value_b, i_ready,
    input  o_ready, o_valid, o_result, o_div_zero
  );

  // Arithmetic core side
  modport slave (
    input  i_valid, i_op, i_value_a, i_value_b, i_ready,
    output o_ready, o_valid, o_result, o_div_zero
  );
endinterface

// File: rtl/seq_arith_core.sv
// Sequential handshaked arithmetic responder: add/sub in one step, multiply by
// LSB-first shift-add and divide by MSB-first restoring division, one bit per
// cycle over DWIDTH cycles. All arithmetic is unsigned, truncated to DWIDTH.
module seq_arith_core #(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  seq_arith_core_if.slave bus
);

  localparam int RW = DWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q;
  op_t               op_in;
  logic [DWIDTH-1:0] a_q;       // mul: shifted multiplicand; div: dividend in, quotient out
  logic [DWIDTH-1:0] b_q;       // mul: shifted multiplier;   div: divisor
  logic [DWIDTH-1:0] acc_q;     // mul partial product
  logic [RW-1:0]     rem_q;     // div partial remainder
  logic [CNT_W-1:0]  cnt_q;
  logic [DWIDTH-1:0] result_q;
  logic              div_zero_q;

  logic              accept;
  logic              last_iter;
  logic [DWIDTH-1:0] mul_acc_nx;
  logic [RW:0]       div_trial;
  logic              div_ge;
  logic [RW-1:0]     div_rem_nx;
  logic [DWIDTH-1:0] div_quo_nx;

  assign op_in     = op_t'(bus.i_op);
  assign accept    = bus.i_valid && (state_q == IDLE);
  assign last_iter = (cnt_q == CNT_W'(DWIDTH - 1));

  assign bus.o_result   = result_q;
  assign bus.o_div_zero = div_zero_q;

  // One shift-add / restoring-division step computed from the current registers
  always_comb begin
    mul_acc_nx = b_q[0] ? (acc_q + a_q) : acc_q;
    div_trial  = {rem_q, a_q[DWIDTH-1]};
    div_ge     = (div_trial >= {2'b00, b_q});
    div_rem_nx = RW'(div_ge ? (div_trial - {2'b00, b_q}) : div_trial);
    div_quo_nx = {a_q[DWIDTH-2:0], div_ge};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          if (op_in == OP_MUL || (op_in == OP_DIV && bus.i_value_b != '0))
            state_d = RUN;
          else
            state_d = DONE;
        end
      end
      RUN: begin
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iterative datapath and held result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            a_q        <= bus.i_value_a;
            b_q        <= bus.i_value_b;
            acc_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
            case (op_in)
              OP_ADD: result_q <= bus.i_value_a + bus.i_value_b;
              OP_SUB: result_q <= bus.i_value_a - bus.i_value_b;
              OP_DIV: begin
                if (bus.i_value_b == '0) begin
                  result_q   <= '1;
                  div_zero_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_nx;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            if (last_iter) result_q <= mul_acc_nx;
          end else begin
            rem_q <= div_rem_nx;
            a_q   <= div_quo_nx;
            if (last_iter) result_q <= div_quo_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_core.sv
// Directed bench for seq_arith_core: vector table for result/flag/latency,
// plus hand-written backpressure, operand-stability and mid-operation reset runs.
module tb_seq_arith_core;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  seq_arith_core_if #(.DWIDTH(8)) bus ();

  seq_arith_core #(.DWIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    logic       exp_dz;
    int         exp_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request, return at the first cycle (sampled #1 after an edge) with o_valid high
  task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic dz, output int lat);
    int guard;
    guard = 0;
    while (!bus.o_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_req", bus.o_ready, 1);
    bus.i_op      = op;
    bus.i_value_a = a;
    bus.i_value_b = b;
    bus.i_valid   = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.o_result;
    dz  = bus.o_div_zero;
  endtask

  logic [7:0] res;
  logic       dz;
  int         lat;
  int         seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{2'd0, 8'd20,  8'd10,  8'd30,  1'b0, 1};
    vecs[1]  = '{2'd1, 8'd20,  8'd10,  8'd10,  1'b0, 1};
    vecs[2]  = '{2'd2, 8'd20,  8'd10,  8'd200, 1'b0, 9};
    vecs[3]  = '{2'd3, 8'd20,  8'd10,  8'd2,   1'b0, 9};
    vecs[4]  = '{2'd0, 8'd100, 8'd200, 8'd44,  1'b0, 1};
    vecs[5]  = '{2'd1, 8'd100, 8'd200, 8'd156, 1'b0, 1};
    vecs[6]  = '{2'd2, 8'd100, 8'd200, 8'd32,  1'b0, 9};
    vecs[7]  = '{2'd3, 8'd100, 8'd200, 8'd0,   1'b0, 9};
    vecs[8]  = '{2'd3, 8'd20,  8'd0,   8'hFF,  1'b1, 1};
    vecs[9]  = '{2'd2, 8'd3,   8'd5,   8'd15,  1'b0, 9};
    vecs[10] = '{2'd3, 8'd255, 8'd1,   8'd255, 1'b0, 9};
    vecs[11] = '{2'd3, 8'd255, 8'd16,  8'd15,  1'b0, 9};
    vecs[12] = '{2'd2, 8'd255, 8'd255, 8'd1,   1'b0, 9};
    vecs[13] = '{2'd0, 8'd255, 8'd1,   8'd0,   1'b0, 1};

    reset_n       = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b1;
    bus.i_op      = 2'd0;
    bus.i_value_a = 8'd0;
    bus.i_value_b = 8'd0;
    #1;
    check("reset_o_ready",    bus.o_ready,    1);
    check("reset_o_valid",    bus.o_valid,    0);
    check("reset_o_result",   bus.o_result,   0);
    check("reset_o_div_zero", bus.o_div_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, i_ready held high
    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].a, vecs[i].b, res, dz, lat);
      check($sformatf("vec%0d_result", i),   res, vecs[i].exp_res);
      check($sformatf("vec%0d_div_zero", i), dz,  vecs[i].exp_dz);
      check($sformatf("vec%0d_latency", i),  lat, vecs[i].exp_lat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid_one_cycle", i), bus.o_valid, 0);
      check($sformatf("vec%0d_ready_after", i),     bus.o_ready, 1);
    end

    // Backpressure: mul 12*12 held for 5 cycles
    bus.i_ready = 1'b0;
    do_req(2'd2, 8'd12, 8'd12, res, dz, lat);
    check("bp_latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      bus.i_value_a = 8'(k + 1);
      check("bp_valid_held",  bus.o_valid,  1);
      check("bp_result_held", bus.o_result, 144);
      check("bp_dz_held",     bus.o_div_zero, 0);
      check("bp_ready_low",   bus.o_ready,  0);
      @(posedge clk); #1;
    end
    check("bp_valid_still", bus.o_valid, 1);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_cleared", bus.o_valid, 0);
    check("bp_ready_back",    bus.o_ready, 1);

    // Operand stability: div 200/7 with inputs churned and i_valid held during RUN
    bus.i_op      = 2'd3;
    bus.i_value_a = 8'd200;
    bus.i_value_b = 8'd7;
    bus.i_valid   = 1'b1;
    @(posedge clk); #1;
    bus.i_op      = 2'd0;
    bus.i_value_a = 8'd5;
    bus.i_value_b = 8'd5;
    lat = 1;
    while (!bus.o_valid && lat < 50) begin
      check("stab_ready_low_run", bus.o_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    bus.i_valid = 1'b0;
    check("stab_latency", lat, 9);
    check("stab_result",  bus.o_result, 28);
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.o_valid) seen++;
      @(posedge clk); #1;
    end
    check("stab_no_extra_resp", seen, 0);

    // Reset mid-operation: mul 255*255, reset after 4 iterations
    bus.i_op      = 2'd2;
    bus.i_value_a = 8'd255;
    bus.i_value_b = 8'd255;
    bus.i_valid   = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_o_valid",  bus.o_valid,  0);
    check("rst_mid_o_ready",  bus.o_ready,  1);
    check("rst_mid_o_result", bus.o_result, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.o_valid) seen++;
    end
    check("rst_no_response", seen, 0);
    do_req(2'd0, 8'd1, 8'd1, res, dz, lat);
    check("rst_after_result",  res, 2);
    check("rst_after_latency", lat, 1);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_arith_core.md
Name: seq_arith_core

Overview:
- Sequential, handshaked arithmetic responder. It serves the same add/sub/mul/div operations as the combinational arithmetic units, one request at a time.
- The requester presents operands and an opcode over a valid/ready request channel.
- The block computes the result, with multiply and divide done iteratively, and returns it over a valid/ready response channel.
- It is the multi-cycle, area-lean counterpart of the combinational units. It is checked against them in the chapter benches.

Parameters:
- DWIDTH, 8, operand and result width in bits.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > DWIDTH.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion clears state immediately; release is synchronous to clk.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request.
- i_op  input  2  opcode: 0 = add, 1 = sub, 2 = mul, 3 = div.
- i_value_a  input  DWIDTH  operand A (unsigned).
- i_value_b  input  DWIDTH  operand B (unsigned).
- o_valid  output  1  response valid.
- i_ready  input  1  requester can take the response.
- o_result  output  DWIDTH  result.
- o_div_zero  output  1  flag returned with the response: the divide had B == 0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state = IDLE, o_ready = 1, o_valid = 0, o_result = 0, o_div_zero = 0, counter = 0, internal operand, accumulator and remainder registers = 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - o_ready = 1.
  - On i_valid && o_ready: latch i_op, A and B.
  - add/sub, or div with B == 0: go to DONE.
  - mul, or div with B != 0: go to RUN, counter = 0.
- RUN:
  - o_ready = 0. Performs exactly DWIDTH iterations, one per cycle.
  - Leaves for DONE on the cycle the counter reaches DWIDTH-1.
- DONE:
  - o_valid = 1. o_result and o_div_zero are held stable until i_ready.
  - On o_valid && i_ready: go to IDLE and clear o_valid.
  - o_ready stays 0 in DONE, so no request is accepted on the response-handshake cycle.
- Latency, measured from the accept edge to the first cycle with o_valid = 1:
  - add/sub/div-by-zero: 1 cycle.
  - mul/div: DWIDTH+1 cycles (9 at the default).
- Throughput: at most one request per 2 cycles for add/sub. With i_ready held high, o_valid is high for exactly one cycle.
- Arithmetic, all unsigned and truncated to DWIDTH bits to match the combinational units:
  - add: (A+B) mod 2^DWIDTH.
  - sub: (A-B) mod 2^DWIDTH, two's-complement wrap.
  - mul: shift-add. LSB-first on B; the accumulator keeps only the low DWIDTH bits of A*B.
  - div: restoring division. Remainder register is DWIDTH+1 bits. One quotient bit per cycle, MSB first. Result = floor(A/B); the remainder is discarded.
- Divide by zero: o_result = all-ones (8'hFF), o_div_zero = 1, latency 1. o_div_zero is 0 for every other response.
- Input changes while in RUN or DONE are ignored; the latched operands are used. i_valid while o_ready = 0 is not consumed. The requester must hold the request until it is accepted.
- Response backpressure: while i_ready = 0 in DONE, o_valid, o_result and o_div_zero must not change.
- Reset mid-operation (in RUN or DONE):
  - The in-flight request is dropped and no response is issued.
  - All outputs return to their reset values immediately.
  - The first request after reset release is accepted normally.
- No X may propagate on o_result for any input, including B == 0.

Test Plan:
- Easy case. A = 20, B = 10, ops add/sub/mul/div in sequence, i_ready = 1:
  - results 30, 10, 200, 2; o_div_zero = 0.
  - add/sub o_valid 1 cycle after accept; mul/div 9 cycles after accept.
- Overflow/wrap case. A = 100, B = 200:
  - add -> 44, sub -> 156, mul -> 32 (20000 mod 256), div -> 0.
  - Each result must equal the combinational unit's output for the same inputs.
- Divide by zero. A = 20, B = 0, op = div:
  - o_valid 1 cycle after accept, o_result = 8'hFF, o_div_zero = 1.
  - Next request mul 3*5 -> 15 with o_div_zero = 0.
- Backpressure. mul 12*12 with i_ready = 0 for 5 cycles after o_valid:
  - o_result stays 144 and o_valid stays 1 throughout; o_ready = 0.
  - Raising i_ready gives one transfer, then o_ready = 1 on the next cycle.
- Operand stability. Accept div 200/7, then change i_value_a/b and pulse i_valid during RUN:
  - result 28; the extra i_valid is not accepted until IDLE.
- Reset mid-operation. Accept mul 255*255, assert reset_n = 0 at iteration 4:
  - o_valid = 0, o_ready = 1, o_result = 0 immediately, and no response appears after release.
  - The next request, add 1+1, returns 2.
